// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for a 4-digit common-anode
// 7-segment display that shares a single external hex decoder.
//
// The controller walks digits 0..3. Each digit gets a guard period with every
// anode off, so the decoder output can settle on the new nibble, followed by
// an ON period with that digit's anode driven low. New display data is staged
// in a shadow register and only copied into the live display register at the
// start of a frame, so a single frame never mixes old and new values.
//
// Ports:
//   clk          - clock, all state updates on the rising edge
//   rst_n        - asynchronous active-low reset
//   enable_i     - 1 = scan digits, 0 = display dark (FSM held in idle)
//   load_i       - single-cycle request to capture data_in_i
//   data_in_i    - four hex digits, [3:0] is digit 0 (rightmost)
//   lz_blank_i   - 1 = suppress leading zeros on digits 3..1
//   seg_in_i     - active-low pattern from the shared decoder for nibble_o
//   nibble_o     - hex value of the current digit, to the shared decoder
//   seg_o        - registered active-low segments to the pins
//   an_o         - active-low anodes, an_o[i] selects digit i
//   load_ack_o   - one-cycle pulse in the cycle after a load is accepted
//   frame_done_o - one-cycle pulse in the last ON cycle of digit 3

module seg_scan_ctrl #(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned GUARD_CYC   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable_i,
    input  logic        load_i,
    input  logic [15:0] data_in_i,
    input  logic        lz_blank_i,
    input  logic [6:0]  seg_in_i,
    output logic [3:0]  nibble_o,
    output logic [6:0]  seg_o,
    output logic [3:0]  an_o,
    output logic        load_ack_o,
    output logic        frame_done_o
);

    localparam int unsigned OnW    = $clog2(REFRESH_DIV + 1);
    localparam int unsigned GuardW = $clog2(GUARD_CYC + 1);

    localparam logic [OnW-1:0]    OnLast    = OnW'(REFRESH_DIV - 1);
    localparam logic [GuardW-1:0] GuardLast = GuardW'(GUARD_CYC - 1);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StGuard = 2'd1;
    localparam logic [1:0] StOn    = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [1:0]        dig_q, dig_d;
    logic [GuardW-1:0] gcnt_q, gcnt_d;
    logic [OnW-1:0]    ocnt_q, ocnt_d;
    logic [15:0]       disp_q, disp_d;
    logic [15:0]       shadow_q, shadow_d;
    logic              pending_q, pending_d;
    logic [6:0]        seg_q, seg_d;
    logic              load_ack_q;

    logic              frame_end;
    logic              frame_start;
    logic [3:0]        lead_zero;
    logic              blank;

    // Scan FSM and its two counters. Dropping enable_i wins over everything.
    always_comb begin
        state_d   = state_q;
        dig_d     = dig_q;
        gcnt_d    = gcnt_q;
        ocnt_d    = ocnt_q;
        frame_end = 1'b0;
        if (!enable_i) begin
            state_d = StIdle;
            dig_d   = 2'd0;
            gcnt_d  = '0;
            ocnt_d  = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    state_d = StGuard;
                    dig_d   = 2'd0;
                    gcnt_d  = '0;
                end
                StGuard: begin
                    if (gcnt_q == GuardLast) begin
                        state_d = StOn;
                        gcnt_d  = '0;
                        ocnt_d  = '0;
                    end else begin
                        gcnt_d = gcnt_q + 1'b1;
                    end
                end
                StOn: begin
                    if (ocnt_q == OnLast) begin
                        state_d   = StGuard;
                        ocnt_d    = '0;
                        dig_d     = dig_q + 2'd1;
                        frame_end = (dig_q == 2'd3);
                    end else begin
                        ocnt_d = ocnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = StIdle;
                    dig_d   = 2'd0;
                    gcnt_d  = '0;
                    ocnt_d  = '0;
                end
            endcase
        end
    end

    // Next edge enters GUARD with dig=0: either leaving idle or wrapping past digit 3.
    assign frame_start = enable_i && ((state_q == StIdle) || frame_end);

    // Shadow/display handoff. A load landing on the frame-start edge bypasses
    // the shadow so the new value is shown in this very frame.
    always_comb begin
        disp_d    = disp_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        if (frame_start && load_i) begin
            disp_d    = data_in_i;
            shadow_d  = data_in_i;
            pending_d = 1'b0;
        end else if (frame_start && pending_q) begin
            disp_d    = shadow_q;
            pending_d = 1'b0;
        end else if (load_i) begin
            shadow_d  = data_in_i;
            pending_d = 1'b1;
        end
    end

    always_comb begin
        case (dig_q)
            2'd0:    nibble_o = disp_q[3:0];
            2'd1:    nibble_o = disp_q[7:4];
            2'd2:    nibble_o = disp_q[11:8];
            default: nibble_o = disp_q[15:12];
        endcase
    end

    // lead_zero[k]: digits k..3 are all zero. Digit 0 always shows.
    always_comb begin
        lead_zero[3] = (disp_q[15:12] == 4'h0);
        lead_zero[2] = lead_zero[3] && (disp_q[11:8] == 4'h0);
        lead_zero[1] = lead_zero[2] && (disp_q[7:4] == 4'h0);
        lead_zero[0] = 1'b0;
    end

    assign blank = lz_blank_i && lead_zero[dig_q];

    always_comb begin
        seg_d = 7'h7F;
        if ((state_q == StOn) && !blank) begin
            seg_d = seg_in_i;
        end
    end

    always_comb begin
        an_o = 4'hF;
        if (state_q == StOn) begin
            an_o[dig_q] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            dig_q      <= 2'd0;
            gcnt_q     <= '0;
            ocnt_q     <= '0;
            disp_q     <= 16'h0000;
            shadow_q   <= 16'h0000;
            pending_q  <= 1'b0;
            seg_q      <= 7'h7F;
            load_ack_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            dig_q      <= dig_d;
            gcnt_q     <= gcnt_d;
            ocnt_q     <= ocnt_d;
            disp_q     <= disp_d;
            shadow_q   <= shadow_d;
            pending_q  <= pending_d;
            seg_q      <= seg_d;
            load_ack_q <= load_i;
        end
    end

    assign seg_o        = seg_q;
    assign load_ack_o   = load_ack_q;
    assign frame_done_o = frame_end;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Testbench for seg_scan_ctrl with REFRESH_DIV=4, GUARD_CYC=1 and a
// behavioural hex decoder on nibble/seg_in. Stimulus pushes expected
// per-digit records (anode, segments, ON length, guard gap, frame_done);
// a negedge monitor collects each anode-low run and compares it.

module tb_seg_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        enable = 1'b0;
    logic        load = 1'b0;
    logic [15:0] data_in = 16'h0000;
    logic        lz_blank = 1'b0;
    logic [6:0]  seg_in;
    logic [3:0]  nibble;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        load_ack;
    logic        frame_done;

    logic [6:0]  seg_lut [16];

    int checks = 0;
    int fails  = 0;
    int loads  = 0;
    int acks   = 0;
    bit mon_en = 1'b0;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        int         len;
        int         gap;
        bit         fd;
    } run_t;

    run_t exp_q[$];

    always #5 clk = ~clk;

    assign seg_in = seg_lut[nibble];

    seg_scan_ctrl #(
        .REFRESH_DIV (4),
        .GUARD_CYC   (1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable_i     (enable),
        .load_i       (load),
        .data_in_i    (data_in),
        .lz_blank_i   (lz_blank),
        .seg_in_i     (seg_in),
        .nibble_o     (nibble),
        .seg_o        (seg),
        .an_o         (an),
        .load_ack_o   (load_ack),
        .frame_done_o (frame_done)
    );

    // ---------------- monitor ----------------
    logic [3:0] run_an = 4'hF;
    logic [6:0] run_seg = 7'h7F;
    int         run_len = 0;
    int         run_gap = 0;
    int         gap = 0;
    bit         run_fd = 1'b0;

    task automatic finish_run();
        run_t e;
        checks++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL run_unexpected: an=%b len=%0d, required no further scan runs",
                     run_an, run_len);
        end else begin
            e = exp_q.pop_front();
            if (run_an !== e.an || run_seg !== e.seg || run_len != e.len ||
                run_fd != e.fd || (e.gap >= 0 && run_gap != e.gap)) begin
                fails++;
                $display("FAIL run: got an=%b seg=%b len=%0d gap=%0d fd=%0d, required an=%b seg=%b len=%0d gap=%0d fd=%0d",
                         run_an, run_seg, run_len, run_gap, run_fd,
                         e.an, e.seg, e.len, e.gap, e.fd);
            end
        end
    endtask

    always @(negedge clk) begin
        if (load_ack === 1'b1) acks++;
        if (!mon_en) begin
            run_len = 0;
            gap     = 0;
        end else if (an === 4'hF) begin
            if (run_len > 0) finish_run();
            run_len = 0;
            gap++;
        end else if (run_len > 0 && an === run_an) begin
            run_len++;
            if (run_len == 2) run_seg = seg;
            if (frame_done === 1'b1) run_fd = 1'b1;
        end else begin
            if (run_len > 0) finish_run();
            run_an  = an;
            run_len = 1;
            run_seg = 7'h7F;
            run_fd  = (frame_done === 1'b1);
            run_gap = gap;
            gap     = 0;
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, got, exp);
        end
    endtask

    task automatic push_digit(input logic [3:0] a, input logic [6:0] s, input int len,
                              input int g, input bit fd);
        run_t r;
        r.an  = a;
        r.seg = s;
        r.len = len;
        r.gap = g;
        r.fd  = fd;
        exp_q.push_back(r);
    endtask

    // blank: hand-computed mask of digits expected dark while their anode is low.
    task automatic push_frame(input logic [15:0] v, input logic [3:0] blank, input bit first);
        for (int d = 0; d < 4; d++) begin
            logic [3:0] nib;
            logic [3:0] a;
            nib = v[d*4 +: 4];
            a = 4'hF;
            a[d] = 1'b0;
            push_digit(a, blank[d] ? 7'h7F : seg_lut[nib], 4,
                       (first && d == 0) ? -1 : 1, d == 3);
        end
    endtask

    task automatic wait_an(input logic [3:0] v);
        int n;
        n = 0;
        checks++;
        do begin
            @(negedge clk);
            n++;
        end while (an !== v && n < 60);
        if (an !== v) begin
            fails++;
            $display("FAIL wait_an: an=%b after %0d cycles, required %b", an, n, v);
        end
    endtask

    task automatic wait_fd();
        int n;
        n = 0;
        checks++;
        do begin
            @(negedge clk);
            n++;
        end while (frame_done !== 1'b1 && n < 60);
        if (frame_done !== 1'b1) begin
            fails++;
            $display("FAIL wait_frame_done: frame_done=%b after %0d cycles, required 1",
                     frame_done, n);
        end
    endtask

    task automatic do_load(input logic [15:0] v);
        @(posedge clk);
        #1;
        load    = 1'b1;
        data_in = v;
        loads++;
        @(posedge clk);
        #1;
        load = 1'b0;
        @(negedge clk);
        chk("load_ack_pulse", {31'd0, load_ack}, 32'd1);
        @(negedge clk);
        chk("load_ack_single", {31'd0, load_ack}, 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        seg_lut[0]  = 7'h40; seg_lut[1]  = 7'h79; seg_lut[2]  = 7'h24; seg_lut[3]  = 7'h30;
        seg_lut[4]  = 7'h19; seg_lut[5]  = 7'h12; seg_lut[6]  = 7'h02; seg_lut[7]  = 7'h78;
        seg_lut[8]  = 7'h00; seg_lut[9]  = 7'h10; seg_lut[10] = 7'h08; seg_lut[11] = 7'h03;
        seg_lut[12] = 7'h46; seg_lut[13] = 7'h21; seg_lut[14] = 7'h06; seg_lut[15] = 7'h0E;

        #2 rst_n = 1'b0;
        #1;
        chk("reset_an", {28'd0, an}, 32'hF);
        chk("reset_seg", {25'd0, seg}, 32'h7F);
        chk("reset_nibble", {28'd0, nibble}, 32'h0);
        chk("reset_load_ack", {31'd0, load_ack}, 32'd0);
        chk("reset_frame_done", {31'd0, frame_done}, 32'd0);
        chk("reset_pending", {31'd0, dut.pending_q}, 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        mon_en = 1'b1;

        // Basic scan of 1234, two frames.
        do_load(16'h1234);
        chk("idle_pending_set", {31'd0, dut.pending_q}, 32'd1);
        chk("idle_disp_unchanged", {16'd0, dut.disp_q}, 32'h0);
        push_frame(16'h1234, 4'b0000, 1'b1);
        push_frame(16'h1234, 4'b0000, 1'b0);
        @(posedge clk);
        #1 enable = 1'b1;
        wait_fd();
        wait_fd();
        @(posedge clk);
        #1 enable = 1'b0;
        chk("disp_1234", {16'd0, dut.disp_q}, 32'h1234);
        chk("pending_cleared", {31'd0, dut.pending_q}, 32'd0);

        // Leading-zero blanking.
        lz_blank = 1'b1;
        do_load(16'h0050);
        push_frame(16'h0050, 4'b1100, 1'b1);
        @(posedge clk);
        #1 enable = 1'b1;
        wait_fd();
        @(posedge clk);
        #1 enable = 1'b0;
        do_load(16'h0000);
        push_frame(16'h0000, 4'b1110, 1'b1);
        @(posedge clk);
        #1 enable = 1'b1;
        wait_fd();
        @(posedge clk);
        #1 enable = 1'b0;
        lz_blank = 1'b0;

        // Mid-frame load, load on the frame-start edge, then disable at dig 1.
        do_load(16'hAAAA);
        push_frame(16'hAAAA, 4'b0000, 1'b1);
        push_frame(16'h5555, 4'b0000, 1'b0);
        push_frame(16'hBEEF, 4'b0000, 1'b0);
        push_digit(4'b1110, seg_lut[15], 4, 1, 1'b0);
        push_digit(4'b1101, seg_lut[14], 2, 1, 1'b0);
        push_frame(16'hBEEF, 4'b0000, 1'b1);
        @(posedge clk);
        #1 enable = 1'b1;
        wait_an(4'b1011);
        do_load(16'h5555);
        chk("midframe_pending", {31'd0, dut.pending_q}, 32'd1);
        chk("midframe_disp_kept", {16'd0, dut.disp_q}, 32'hAAAA);
        wait_fd();
        wait_an(4'b0111);
        repeat (2) @(posedge clk);
        do_load(16'hBEEF);
        chk("bypass_pending_zero", {31'd0, dut.pending_q}, 32'd0);
        chk("bypass_disp", {16'd0, dut.disp_q}, 32'hBEEF);
        wait_fd();
        wait_an(4'b1101);
        @(posedge clk);
        #1 enable = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("disable_an_dark", {28'd0, an}, 32'hF);
        chk("disable_no_frame_done", {31'd0, frame_done}, 32'd0);
        repeat (3) @(posedge clk);
        #1 enable = 1'b1;
        wait_fd();

        // Asynchronous reset in the middle of an ON period.
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 mon_en = 1'b0;
        @(posedge clk);
        #3;
        chk("pre_reset_an", {28'd0, an}, 32'hE);
        chk("pre_reset_seg", {25'd0, seg}, {25'd0, seg_lut[15]});
        rst_n = 1'b0;
        #1;
        chk("async_reset_an", {28'd0, an}, 32'hF);
        chk("async_reset_seg", {25'd0, seg}, 32'h7F);
        chk("async_reset_disp", {16'd0, dut.disp_q}, 32'h0);
        chk("async_reset_nibble", {28'd0, nibble}, 32'h0);
        chk("async_reset_frame_done", {31'd0, frame_done}, 32'd0);
        enable = 1'b0;
        #20 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_reset_idle_an", {28'd0, an}, 32'hF);

        chk("scoreboard_drained", exp_q.size(), 32'd0);
        chk("load_ack_count", acks, loads);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter REFRESH_DIV, default 100000: clk cycles each digit anode stays active; legal range 2 or more.
REQ-002 Parameter GUARD_CYC, default 4: clk cycles with all anodes off before each digit (anti-ghosting); legal range 1 or more.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 enable  input  1  1 = scan digits, 0 = display dark.
REQ-006 load  input  1  single-cycle request to capture data_in.
REQ-007 data_in  input  16  four hex digits; [3:0] is digit 0 (rightmost), [15:12] is digit 3.
REQ-008 lz_blank  input  1  1 = suppress leading zeros.
REQ-009 seg_in  input  7  active-low segment pattern returned by the shared SevenSeg_Display decoder for nibble.
REQ-010 nibble  output  4  hex value driven to the shared decoder SW input.
REQ-011 seg  output  7  active-low segments to the pins.
REQ-012 an  output  4  active-low anodes; an[i] selects digit i.
REQ-013 load_ack  output  1  one-cycle pulse, cycle after load is accepted.
REQ-014 frame_done  output  1  one-cycle pulse when digit 3's ON period ends.

Function
REQ-015 The FSM SHALL have states IDLE, GUARD, ON and a 2-bit digit index dig.
- IDLE: an=4'b1111; when enable=1, go to GUARD with dig=0.
- GUARD: an=4'b1111 for GUARD_CYC cycles, then go to ON.
- ON: an[dig]=0 for REFRESH_DIV cycles; then dig increments mod 4 (3 wraps to 0) and the FSM goes to GUARD.
REQ-016 In any state, enable=0 SHALL force IDLE on the next edge, with dig=0 and counters cleared.
REQ-017 nibble SHALL equal disp[4*dig+3:4*dig] during both GUARD and ON, so the decoder output is settled before its anode turns on.
REQ-018 seg SHALL be registered:
- ON with the digit not blanked: seg = seg_in.
- Otherwise: seg = 7'b1111111.
- Result: one cycle of latency from state to seg.
REQ-019 load SHALL write data_in into a shadow register and set pending; load_ack SHALL pulse on the following cycle; load is always accepted.
REQ-020 Shadow-to-disp transfer SHALL occur only on entry to GUARD with dig=0, and only when pending=1; the transfer clears pending, so a frame never shows mixed values.
REQ-021 If load coincides with the transfer cycle, data_in SHALL go directly to disp and pending SHALL remain 0.
REQ-022 On IDLE-to-GUARD entry, a pending shadow SHALL transfer as well.
REQ-023 With lz_blank=1, digit k (k=3,2,1) SHALL be blanked when disp digits k through 3 are all 0; digit 0 is never blanked.
REQ-024 frame_done SHALL pulse in the cycle the FSM leaves ON with dig=3; it does not pulse if enable drops mid-frame.
REQ-025 Each counter SHALL be sized to hold its parameter value; a counter SHALL never wrap past its terminal count.

Reset
REQ-026 rst_n=0 SHALL immediately set:
- state=IDLE, dig=0, counters=0.
- disp=0, shadow=0, pending=0.
- an=4'b1111, seg=7'b1111111, nibble=0, load_ack=0, frame_done=0.
REQ-027 On rst_n deassertion, the first scan SHALL begin on the first edge with enable=1, starting at GUARD with dig=0; a reset mid-scan aborts the scan with no glitch pulse.

Verification
All scenarios use REFRESH_DIV=4, GUARD_CYC=1, and a real SevenSeg_Display instance on nibble/seg_in.
REQ-028 Reset, load 16'h1234, enable=1 -> anode sequence is 1110 (4 cycles), 1101, 1011, 0111, each preceded by 1 cycle of 1111; seg follows the decoder patterns for 4, 3, 2, 1; frame_done pulses every 20 cycles.
REQ-029 lz_blank=1, data 16'h0050 -> digits 3 and 2 show seg=7'b1111111 while their anodes are low; digit 1 shows "5" and digit 0 shows "0". With data 16'h0000, only digit 0 is lit, showing "0".
REQ-030 Load 16'hAAAA, then load 16'h5555 mid-frame at dig=2 -> the remainder of that frame shows A; the next frame shows 5; load_ack pulses exactly once per load.
REQ-031 load 16'hBEEF asserted in the exact cycle of GUARD entry with dig=0 -> that same frame's digit 0 shows F; pending reads 0.
REQ-032 enable=0 during ON at dig=1 -> next cycle an=1111, no frame_done pulse; re-enable -> scan restarts at dig=0.
REQ-033 rst_n pulsed low asynchronously, between clk edges, during ON -> an and seg go all ones without waiting for a clk edge, and disp reads 0.
